// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA raster timing generator.
//   - default 640x480@60 timing constants (25.175 MHz dot clock)
//   - default counter / colour widths and pixel-source latency
//   - sync polarity constants
//   - raster segment and colour-bar enumerations
//   - bar_rgb(): colour-bar index -> {R,G,B} on/off bits
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_CNT_W    = 12;
    localparam int unsigned VGA_COLOR_W  = 8;
    localparam int unsigned VGA_PIX_LAT  = 1;

    localparam logic POL_LOW  = 1'b0;
    localparam logic POL_HIGH = 1'b1;

    // Position of a counter within one line/frame, in raster order.
    typedef enum logic [1:0] {
        SEG_ACTIVE,
        SEG_FRONT,
        SEG_SYNC,
        SEG_BACK
    } seg_e;

    // Raster flags carried through the latency-matching delay line.
    typedef struct packed {
        logic hs;   // inside horizontal sync pulse
        logic vs;   // inside vertical sync pulse
        logic act;  // inside active video area
    } sync_flags_t;

    // Colour bars, left to right.
    typedef enum logic [2:0] {
        BAR_WHITE   = 3'd0,
        BAR_YELLOW  = 3'd1,
        BAR_CYAN    = 3'd2,
        BAR_GREEN   = 3'd3,
        BAR_MAGENTA = 3'd4,
        BAR_RED     = 3'd5,
        BAR_BLUE    = 3'd6,
        BAR_BLACK   = 3'd7
    } bar_e;

    // Returns {R,G,B} channel-enable bits for a colour-bar index.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        rgb = 3'b000;
        case (bar_e'(idx))
            BAR_WHITE:   rgb = 3'b111;
            BAR_YELLOW:  rgb = 3'b110;
            BAR_CYAN:    rgb = 3'b011;
            BAR_GREEN:   rgb = 3'b010;
            BAR_MAGENTA: rgb = 3'b101;
            BAR_RED:     rgb = 3'b100;
            BAR_BLUE:    rgb = 3'b001;
            BAR_BLACK:   rgb = 3'b000;
            default:     rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-fetch and video-out signal bundle of vga_timing_gen.
//   master (generator): drives x, y, pix_req, line_start, frame_start,
//                       hsync, vsync, de, red, green, blue; reads rgb_in
//   slave  (source/DAC side): the mirror image
// Parameters: CNT_W (coordinate width), COLOR_W (bits per colour channel).
interface vga_timing_gen_if
    import vga_pkg::*;
#(
    parameter int unsigned CNT_W   = VGA_CNT_W,
    parameter int unsigned COLOR_W = VGA_COLOR_W
);

    // pixel fetch side
    logic [CNT_W-1:0]     x;
    logic [CNT_W-1:0]     y;
    logic                 pix_req;
    logic                 line_start;
    logic                 frame_start;
    logic [3*COLOR_W-1:0] rgb_in;

    // video output side
    logic                 hsync;
    logic                 vsync;
    logic                 de;
    logic [COLOR_W-1:0]   red;
    logic [COLOR_W-1:0]   green;
    logic [COLOR_W-1:0]   blue;

    modport master (
        output x, y, pix_req, line_start, frame_start,
        output hsync, vsync, de, red, green, blue,
        input  rgb_in
    );

    modport slave (
        input  x, y, pix_req, line_start, frame_start,
        input  hsync, vsync, de, red, green, blue,
        output rgb_in
    );

endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: WIDTH-bit, DEPTH-stage shift register.
//   clk    in   clock
//   rst_n  in   asynchronous active-low clear (all stages to CLR_VAL)
//   enable in   shift when high, hold when low
//   din    in   WIDTH  data into stage 0
//   dout   out  WIDTH  data from last stage (DEPTH cycles after din)
// DEPTH must be at least 1.
module vga_delay_line #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      DEPTH   = 1,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= CLR_VAL;
            end
        end else if (enable) begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   clk     in   dot clock
//   rst_n   in   asynchronous active-low reset
//   enable  in   advance the raster when high; freeze all state when low
//   bus     vga_timing_gen_if.master:
//     x, y         out  current raster position (stage 1)
//     pix_req      out  x/y inside the active area
//     line_start   out  pulse at h == 0
//     frame_start  out  pulse at h == 0, v == 0
//     rgb_in       in   {R,G,B} from the pixel source, PIX_LAT cycles after x/y
//     hsync, vsync out  registered syncs, asserted level HS_POL / VS_POL
//     de           out  active-video flag aligned with RGB
//     red/green/blue out registered pixel, zero during blanking
// Build option: define VGA_TEST_PATTERN_EN to replace rgb_in with eight
// vertical colour bars generated from the delayed x coordinate.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        HS_POL   = POL_LOW,
    parameter logic        VS_POL   = POL_LOW,
    parameter int unsigned CNT_W    = VGA_CNT_W,
    parameter int unsigned COLOR_W  = VGA_COLOR_W,
    parameter int unsigned PIX_LAT  = VGA_PIX_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    vga_timing_gen_if.master  bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_FP_START   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_BP_START   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);

    localparam logic [CNT_W-1:0] V_FP_START   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_BP_START   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);

    // Sync/active flags are taken from the counters, one stage ahead of
    // x/y, so PIX_LAT+1 stages here plus the output register land them
    // on the same edge that captures rgb_in.
    localparam int unsigned DL_DEPTH = PIX_LAT + 1;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (enable) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Segment decode
    // ------------------------------------------------------------------
    seg_e        h_seg;
    seg_e        v_seg;
    sync_flags_t raster_flags;

    always_comb begin
        h_seg = SEG_BACK;
        if (h_cnt < H_FP_START) begin
            h_seg = SEG_ACTIVE;
        end else if (h_cnt < H_SYNC_START) begin
            h_seg = SEG_FRONT;
        end else if (h_cnt < H_BP_START) begin
            h_seg = SEG_SYNC;
        end
    end

    always_comb begin
        v_seg = SEG_BACK;
        if (v_cnt < V_FP_START) begin
            v_seg = SEG_ACTIVE;
        end else if (v_cnt < V_SYNC_START) begin
            v_seg = SEG_FRONT;
        end else if (v_cnt < V_BP_START) begin
            v_seg = SEG_SYNC;
        end
    end

    always_comb begin
        raster_flags     = '0;
        raster_flags.hs  = (h_seg == SEG_SYNC);
        raster_flags.vs  = (v_seg == SEG_SYNC);
        raster_flags.act = (h_seg == SEG_ACTIVE) && (v_seg == SEG_ACTIVE);
    end

    // ------------------------------------------------------------------
    // Stage 1: pixel fetch request
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] x_q;
    logic [CNT_W-1:0] y_q;
    logic             pix_req_q;
    logic             line_start_q;
    logic             frame_start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            pix_req_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (enable) begin
            x_q           <= h_cnt;
            y_q           <= v_cnt;
            pix_req_q     <= raster_flags.act;
            line_start_q  <= (h_cnt == '0);
            frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.pix_req     = pix_req_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;

    // ------------------------------------------------------------------
    // Latency matching
    // ------------------------------------------------------------------
    sync_flags_t flags_d;

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (DL_DEPTH),
        .CLR_VAL (3'b000)
    ) u_flags_dl (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .din    (raster_flags),
        .dout   (flags_d)
    );

    // ------------------------------------------------------------------
    // Pixel source
    // ------------------------------------------------------------------
    logic [3*COLOR_W-1:0] pix_src;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'((H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8);

    logic [CNT_W-1:0] x_d;
    logic [CNT_W-1:0] bar_full;
    logic [2:0]       bar_idx;
    logic [2:0]       bar_bits;

    vga_delay_line #(
        .WIDTH   (CNT_W),
        .DEPTH   (DL_DEPTH),
        .CLR_VAL ('0)
    ) u_x_dl (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .din    (h_cnt),
        .dout   (x_d)
    );

    assign bar_full = x_d / BAR_W;
    // Past the last bar (only reachable in blanking) saturate to black.
    assign bar_idx  = (bar_full > CNT_W'(7)) ? 3'd7 : bar_full[2:0];
    assign bar_bits = bar_rgb(bar_idx);
    assign pix_src  = {{COLOR_W{bar_bits[2]}},
                       {COLOR_W{bar_bits[1]}},
                       {COLOR_W{bar_bits[0]}}};
`else
    assign pix_src = bus.rgb_in;
`endif

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic                 hsync_q;
    logic                 vsync_q;
    logic                 de_q;
    logic [3*COLOR_W-1:0] rgb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            rgb_q   <= '0;
        end else if (enable) begin
            hsync_q <= flags_d.hs ? HS_POL : ~HS_POL;
            vsync_q <= flags_d.vs ? VS_POL : ~VS_POL;
            de_q    <= flags_d.act;
            rgb_q   <= flags_d.act ? pix_src : '0;
        end
    end

    assign bus.hsync = hsync_q;
    assign bus.vsync = vsync_q;
    assign bus.de    = de_q;
    assign bus.red   = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign bus.green = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue  = rgb_q[COLOR_W-1   -: COLOR_W];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen.
// Two instances on a shrunken raster (24x13 totals):
//   u0: PIX_LAT=3, active-low syncs
//   u1: PIX_LAT=0, active-high syncs
// Expected values come from a position-count model: after k enabled edges
// since reset, stage 1 holds raster position k-1 and the output stage holds
// position k-2-PIX_LAT, decoded with plain arithmetic.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int CW = 12, COL = 8;
    localparam int LAT0 = 3, LAT1 = 0;
    localparam int POL0 = 0, POL1 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(CW), .COLOR_W(COL)) bus0 ();
    vga_timing_gen_if #(.CNT_W(CW), .COLOR_W(COL)) bus1 ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .CNT_W(CW), .COLOR_W(COL), .PIX_LAT(LAT0)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus0)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .CNT_W(CW), .COLOR_W(COL), .PIX_LAT(LAT1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus1)
    );

    int tests = 0;
    int fails = 0;
    int k = 0;                  // enabled edges since reset release
    logic [23:0] pix_tab [FRAME];

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [2:0] BAR_TAB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                           3'b101, 3'b100, 3'b001, 3'b000};
`endif

    task automatic chk(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", nm, act, expv, k, $time);
        end
    endtask

    // Pixel the source returns for raster position q.
    function automatic logic [23:0] src_pix(input int q);
        int h, v;
        if (q < 0) return 24'($urandom);
        h = q % HT;
        v = (q / HT) % VT;
        return pix_tab[v * HT + h];
    endfunction

    // Pixel expected on the DAC pins for an active position.
    function automatic logic [23:0] exp_pix(input int h, input int v);
`ifdef VGA_TEST_PATTERN_EN
        logic [2:0] b;
        b = BAR_TAB[h / (HA / 8)];
        return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
`else
        return pix_tab[v * HT + h];
`endif
    endfunction

    task automatic drive_rgb();
        bus0.rgb_in = src_pix(k - 1 - LAT0);
        bus1.rgb_in = src_pix(k - 1 - LAT1);
    endtask

    task automatic check_inst(input string nm, input int lat, input int pol,
                              input int ax, input int ay, input int apr,
                              input int als, input int afs, input int ahs,
                              input int avs, input int ade, input int ar,
                              input int ag, input int ab);
        int ex, ey, epr, els, efs, ehs, evs, ede;
        int h, v, p2;
        logic [23:0] px;
        ex = 0; ey = 0; epr = 0; els = 0; efs = 0;
        if (k > 0) begin
            h = (k - 1) % HT;
            v = ((k - 1) / HT) % VT;
            ex = h; ey = v;
            epr = (h < HA && v < VA) ? 1 : 0;
            els = (h == 0) ? 1 : 0;
            efs = (h == 0 && v == 0) ? 1 : 0;
        end
        ehs = 1 - pol; evs = 1 - pol; ede = 0; px = '0;
        p2 = k - 2 - lat;
        if (p2 >= 0) begin
            h = p2 % HT;
            v = (p2 / HT) % VT;
            if (h >= HA + HF && h < HA + HF + HS) ehs = pol;
            if (v >= VA + VF && v < VA + VF + VS) evs = pol;
            if (h < HA && v < VA) begin
                ede = 1;
                px = exp_pix(h, v);
            end
        end
        chk({nm, ".x"}, ax, ex);
        chk({nm, ".y"}, ay, ey);
        chk({nm, ".pix_req"}, apr, epr);
        chk({nm, ".line_start"}, als, els);
        chk({nm, ".frame_start"}, afs, efs);
        chk({nm, ".hsync"}, ahs, ehs);
        chk({nm, ".vsync"}, avs, evs);
        chk({nm, ".de"}, ade, ede);
        chk({nm, ".red"}, ar, int'(px[23:16]));
        chk({nm, ".green"}, ag, int'(px[15:8]));
        chk({nm, ".blue"}, ab, int'(px[7:0]));
    endtask

    task automatic check_all();
        check_inst("u0", LAT0, POL0, int'(bus0.x), int'(bus0.y), int'(bus0.pix_req),
                   int'(bus0.line_start), int'(bus0.frame_start), int'(bus0.hsync),
                   int'(bus0.vsync), int'(bus0.de), int'(bus0.red), int'(bus0.green),
                   int'(bus0.blue));
        check_inst("u1", LAT1, POL1, int'(bus1.x), int'(bus1.y), int'(bus1.pix_req),
                   int'(bus1.line_start), int'(bus1.frame_start), int'(bus1.hsync),
                   int'(bus1.vsync), int'(bus1.de), int'(bus1.red), int'(bus1.green),
                   int'(bus1.blue));
    endtask

    // One clock: apply enable, advance the model, present rgb_in, check at negedge.
    task automatic step(input logic en);
        enable = en;
        @(posedge clk);
        #1;
        if (!rst_n) k = 0;
        else if (en) k++;
        drive_rgb();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        int adv;
        int ex, ey;
        int epr, els, efs;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_ls, cnt_fs, cnt_de, cnt_hs0, cnt_vs0, cnt_hs1;

        // {edges to advance, x, y, pix_req, line_start, frame_start}
        vecs[0] = '{1,   0,  0, 1, 1, 1};
        vecs[1] = '{1,   1,  0, 1, 0, 0};
        vecs[2] = '{14, 15,  0, 1, 0, 0};
        vecs[3] = '{1,  16,  0, 0, 0, 0};
        vecs[4] = '{8,   0,  1, 1, 1, 0};
        vecs[5] = '{168, 0,  8, 0, 1, 0};
        vecs[6] = '{119, 23, 12, 0, 0, 0};
        vecs[7] = '{1,   0,  0, 1, 1, 1};

        for (int i = 0; i < FRAME; i++) pix_tab[i] = 24'($urandom);

        // Reset held with clock running.
        k = 0;
        drive_rgb();
        repeat (4) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Directed raster positions.
        for (int i = 0; i < 8; i++) begin
            repeat (vecs[i].adv) step(1'b1);
            chk($sformatf("vec%0d.x", i), int'(bus0.x), vecs[i].ex);
            chk($sformatf("vec%0d.y", i), int'(bus0.y), vecs[i].ey);
            chk($sformatf("vec%0d.pix_req", i), int'(bus0.pix_req), vecs[i].epr);
            chk($sformatf("vec%0d.line_start", i), int'(bus0.line_start), vecs[i].els);
            chk($sformatf("vec%0d.frame_start", i), int'(bus0.frame_start), vecs[i].efs);
        end

        // One full frame of pulses and levels.
        cnt_ls = 0; cnt_fs = 0; cnt_de = 0; cnt_hs0 = 0; cnt_vs0 = 0; cnt_hs1 = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1);
            cnt_ls  += int'(bus0.line_start);
            cnt_fs  += int'(bus0.frame_start);
            cnt_de  += int'(bus0.de);
            cnt_hs0 += int'(!bus0.hsync);
            cnt_vs0 += int'(!bus0.vsync);
            cnt_hs1 += int'(bus1.hsync);
        end
        chk("frame.line_start_count", cnt_ls, VT);
        chk("frame.frame_start_count", cnt_fs, 1);
        chk("frame.de_count", cnt_de, HA * VA);
        chk("frame.hsync_low_count", cnt_hs0, HS * VT);
        chk("frame.vsync_low_count", cnt_vs0, VS * HT);
        chk("frame.hsync_high_count_u1", cnt_hs1, HS * VT);

        // Freeze mid-line for 50 cycles.
        for (int i = 0; i < 2 * HT && ((k - 1) % HT) != 10; i++) step(1'b1);
        chk("hold.start_x", int'(bus0.x), 10);
        for (int i = 0; i < 50; i++) begin
            step(1'b0);
            chk("hold.x", int'(bus0.x), 10);
        end
        step(1'b1);
        chk("hold.resume_x", int'(bus0.x), 11);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < FRAME + HT && !(((k - 1) % HT) == 12 && (((k - 1) / HT) % VT) == 5); i++)
            step(1'b1);
        chk("rst.pre_y", int'(bus0.y), 5);
        #2;
        rst_n = 1'b0;
        #1;
        k = 0;
        drive_rgb();
        check_all();
        repeat (3) step(1'b1);
        rst_n = 1'b1;
        step(1'b1);
        chk("rst.resume_frame_start", int'(bus0.frame_start), 1);
        chk("rst.resume_x", int'(bus0.x), 0);

        // Random enable pattern over several frames.
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
